// File: rtl/cde_inverse_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : cde_inverse_scanner_if
// Brief    : Request / result handshake bundle for the {c,d,e} inverse scanner
// Revision : 1.0
// ============================================================================
interface cde_inverse_scanner_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_target;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_code;
    logic       busy;
    logic       done;
    logic [4:0] match_count;

    modport master (
        output req_valid, req_target, m_ready,
        input  req_ready, m_valid, m_code, busy, done, match_count
    );

    modport slave (
        input  req_valid, req_target, m_ready,
        output req_ready, m_valid, m_code, busy, done, match_count
    );
endinterface
`default_nettype wire

// File: rtl/cde_inverse_scanner.sv
`default_nettype none
// ============================================================================
// Module   : cde_inverse_scanner
// Brief    : Scans all 16 {x,y,w,z} codes and streams those decoding to a target
// Revision : 1.0
// ============================================================================
module cde_inverse_scanner #(
    parameter bit DESCENDING = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    cde_inverse_scanner_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] C_FIRST = DESCENDING ? 4'd15 : 4'd0;
    localparam logic [3:0] C_LAST  = DESCENDING ? 4'd0  : 4'd15;

    function automatic logic [2:0] decode(input logic [3:0] code);
        logic [2:0] f;
        case (code)
            4'd0:    f = 3'b010;
            4'd1:    f = 3'b101;
            4'd2:    f = 3'b111;
            4'd3:    f = 3'b001;
            4'd4:    f = 3'b000;
            4'd5:    f = 3'b010;
            4'd6:    f = 3'b111;
            4'd7:    f = 3'b110;
            4'd8:    f = 3'b001;
            4'd9:    f = 3'b100;
            4'd10:   f = 3'b110;
            4'd11:   f = 3'b100;
            4'd12:   f = 3'b000;
            4'd13:   f = 3'b010;
            4'd14:   f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    state_t     r_state;
    logic [3:0] r_idx;
    logic [2:0] r_target;
    logic [4:0] r_count;
    logic       r_req_ready;
    logic       r_m_valid;
    logic [3:0] r_m_code;
    logic       r_busy;
    logic       r_done;
    logic [4:0] r_match_count;

    logic       w_last;
    logic       w_hit;
    logic [3:0] w_next;

    assign w_last = (r_idx == C_LAST);
    assign w_hit  = (decode(r_idx) == r_target);
    assign w_next = DESCENDING ? (r_idx - 4'd1) : (r_idx + 4'd1);

    // match_count is loaded on entry to DONE so it is valid alongside the done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= 4'd0;
            r_target      <= 3'd0;
            r_count       <= 5'd0;
            r_req_ready   <= 1'b1;
            r_m_valid     <= 1'b0;
            r_m_code      <= 4'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_match_count <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_target    <= bus.req_target;
                        r_idx       <= C_FIRST;
                        r_count     <= 5'd0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_m_code  <= r_idx;
                        r_m_valid <= 1'b1;
                        r_state   <= S_EMIT;
                    end else if (w_last) begin
                        r_match_count <= r_count;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_idx <= w_next;
                    end
                end
                S_EMIT: begin
                    if (bus.m_ready) begin
                        r_count   <= r_count + 5'd1;
                        r_m_valid <= 1'b0;
                        if (w_last) begin
                            r_match_count <= r_count + 5'd1;
                            r_done        <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_idx   <= w_next;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_code      = r_m_code;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.match_count = r_match_count;
endmodule
`default_nettype wire

// File: tb/tb_cde_inverse_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_cde_inverse_scanner
// Brief    : Bench for cde_inverse_scanner, ascending and descending instances
// Revision : 1.0
// ============================================================================
module tb_cde_inverse_scanner;
    localparam logic [15:0] C_SET = (16'd1 << 1) | (16'd1 << 2) | (16'd1 << 6) | (16'd1 << 7)
                                  | (16'd1 << 9) | (16'd1 << 10) | (16'd1 << 11);
    localparam logic [15:0] D_SET = (16'd1 << 0) | (16'd1 << 2) | (16'd1 << 5) | (16'd1 << 6)
                                  | (16'd1 << 7) | (16'd1 << 10) | (16'd1 << 13);
    localparam logic [15:0] E_SET = (16'd1 << 1) | (16'd1 << 2) | (16'd1 << 3) | (16'd1 << 6)
                                  | (16'd1 << 8) | (16'd1 << 14);

    logic       clk;
    logic       reset;
    logic       cur;
    logic       drv_valid;
    logic [2:0] drv_target;
    logic       drv_ready;
    int         n_total;
    int         n_bad;

    cde_inverse_scanner_if ba();
    cde_inverse_scanner_if bd();

    cde_inverse_scanner #(.DESCENDING(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ba));
    cde_inverse_scanner #(.DESCENDING(1'b1)) dut_d (.clk(clk), .reset(reset), .bus(bd));

    assign ba.req_valid  = (cur == 1'b0) ? drv_valid : 1'b0;
    assign bd.req_valid  = (cur == 1'b1) ? drv_valid : 1'b0;
    assign ba.req_target = drv_target;
    assign bd.req_target = drv_target;
    assign ba.m_ready    = (cur == 1'b0) ? drv_ready : 1'b0;
    assign bd.m_ready    = (cur == 1'b1) ? drv_ready : 1'b0;

    logic       s_req_ready;
    logic       s_m_valid;
    logic [3:0] s_m_code;
    logic       s_busy;
    logic       s_done;
    logic [4:0] s_match_count;

    assign s_req_ready   = cur ? bd.req_ready   : ba.req_ready;
    assign s_m_valid     = cur ? bd.m_valid     : ba.m_valid;
    assign s_m_code      = cur ? bd.m_code      : ba.m_code;
    assign s_busy        = cur ? bd.busy        : ba.busy;
    assign s_done        = cur ? bd.done        : ba.done;
    assign s_match_count = cur ? bd.match_count : ba.match_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_f(input int code);
        return {C_SET[code], D_SET[code], E_SET[code]};
    endfunction

    task automatic run_scan(input logic sel, input logic [2:0] tgt, input int first_stall,
                            input bit rnd_stall, input bit poke_req, input bit reset_emit);
        int   exp_q[$];
        int   k;
        int   cycles;
        int   stalls;
        int   stall_cnt;
        int   done_seen;
        bit   pend;
        bit   finished;
        bit   rdy;
        logic [3:0] pend_code;
        cur = sel;
        for (int i = 0; i < 16; i++) begin
            int code;
            code = sel ? 15 - i : i;
            if (ref_f(code) == tgt) exp_q.push_back(code);
        end
        k = 0; cycles = 0; stalls = 0; stall_cnt = 0; done_seen = 0;
        pend = 0; finished = 0; pend_code = 4'd0;
        @(negedge clk);
        check("idle_ready", s_req_ready, 1);
        drv_valid  = 1'b1;
        drv_target = tgt;
        drv_ready  = 1'b0;
        @(posedge clk);
        for (int guard = 0; guard < 400; guard++) begin
            @(negedge clk);
            drv_valid = 1'b0;
            if (s_req_ready) begin
                finished = 1;
                break;
            end
            check("busy", s_busy, 1);
            if (poke_req && cycles == 3) begin
                drv_valid  = 1'b1;
                drv_target = ~tgt;
            end
            if (s_done) begin
                done_seen++;
                check("done_count", s_match_count, exp_q.size());
                check("done_after_all", k, exp_q.size());
            end
            if (pend) check("valid_held", s_m_valid, 1);
            if (s_m_valid) begin
                if (!pend) begin
                    if (k < exp_q.size()) check("code", s_m_code, exp_q[k]);
                    else                  check("unexpected_valid", s_m_valid, 0);
                    pend      = 1;
                    pend_code = s_m_code;
                end else begin
                    check("code_stable", s_m_code, pend_code);
                end
            end
            if (s_m_valid && k == 0 && stall_cnt < first_stall) begin
                rdy = 0;
                stall_cnt++;
            end else begin
                rdy = rnd_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            drv_ready = rdy;
            if (s_m_valid && !rdy) stalls++;
            if (s_m_valid && rdy) begin
                pend = 0;
                k++;
            end
            if (reset_emit && s_m_valid) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_m_valid", s_m_valid, 0);
                check("rst_req_ready", s_req_ready, 1);
                check("rst_busy", s_busy, 0);
                check("rst_done", s_done, 0);
                check("rst_match_count", s_match_count, 0);
                reset     = 1'b0;
                drv_ready = 1'b0;
                return;
            end
            @(posedge clk);
            cycles++;
        end
        drv_ready = 1'b0;
        if (!finished) begin
            check("timeout", 0, 1);
            return;
        end
        check("latency", cycles, 17 + exp_q.size() + stalls);
        check("emitted", k, exp_q.size());
        check("done_pulses", done_seen, 1);
        check("count_held", s_match_count, exp_q.size());
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        cur = 1'b0; drv_valid = 1'b0; drv_target = 3'd0; drv_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready_a", ba.req_ready, 1);
        check("reset_valid_a", ba.m_valid, 0);
        check("reset_code_a", ba.m_code, 0);
        check("reset_busy_a", ba.busy, 0);
        check("reset_done_a", ba.done, 0);
        check("reset_count_a", ba.match_count, 0);
        check("reset_ready_d", bd.req_ready, 1);
        check("reset_valid_d", bd.m_valid, 0);
        check("reset_count_d", bd.match_count, 0);
        reset = 1'b0;

        run_scan(1'b0, 3'b011, 0, 0, 0, 0);
        run_scan(1'b0, 3'b010, 0, 0, 0, 0);
        run_scan(1'b0, 3'b111, 5, 0, 1, 0);
        run_scan(1'b1, 3'b001, 0, 0, 0, 0);
        run_scan(1'b0, 3'b000, 0, 0, 0, 1);
        run_scan(1'b0, 3'b000, 0, 0, 0, 0);

        for (int t = 0; t < 24; t++) begin
            run_scan(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
